// File: rtl/axis_to_dcmac.sv
// AXI stream to DCMAC segmented TX converter: a two-entry FIFO of beats that are
// formatted into per-segment {err, sop, ena}/tlast on entry, plus packet and violation counters.
module axis_to_dcmac #(
    parameter int SEG_COUNT = 4,
    parameter int DW        = 128*SEG_COUNT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   axis_in_tdata,
    input  logic [DW/8-1:0] axis_in_tkeep,
    input  logic            axis_in_tuser,
    input  logic            axis_in_tlast,
    input  logic            axis_in_tvalid,
    output logic            axis_in_tready,
    output logic [127:0]    seg0_tdata,
    output logic [15:0]     seg0_tkeep,
    output logic [2:0]      seg0_tuser,
    output logic            seg0_tlast,
    output logic            seg0_tvalid,
    input  logic            seg0_tready,
    output logic [127:0]    seg1_tdata,
    output logic [15:0]     seg1_tkeep,
    output logic [2:0]      seg1_tuser,
    output logic            seg1_tlast,
    output logic            seg1_tvalid,
    input  logic            seg1_tready,
    output logic [127:0]    seg2_tdata,
    output logic [15:0]     seg2_tkeep,
    output logic [2:0]      seg2_tuser,
    output logic            seg2_tlast,
    output logic            seg2_tvalid,
    input  logic            seg2_tready,
    output logic [127:0]    seg3_tdata,
    output logic [15:0]     seg3_tkeep,
    output logic [2:0]      seg3_tuser,
    output logic            seg3_tlast,
    output logic            seg3_tvalid,
    input  logic            seg3_tready,
    output logic [31:0]     pkt_count,
    output logic [15:0]     viol_count,
    output logic            viol_sticky
);

    localparam int KW = DW/8;

    typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

    state_t                      state_r, state_nxt_s;
    logic [DW-1:0]               data_r [2];
    logic [KW-1:0]               keep_r [2];
    logic [SEG_COUNT-1:0][2:0]   user_r [2];
    logic [SEG_COUNT-1:0]        last_r [2];
    logic                        wr_ptr_r, rd_ptr_r;
    logic [1:0]                  count_r;
    logic                        rdy_en_r;
    logic [31:0]                 pkt_count_r;
    logic [15:0]                 viol_count_r;
    logic                        viol_sticky_r;

    logic                        push_s, pop_s, nonempty_s, seg_rdy_all_s;
    logic [3:0]                  seg_tready_s;
    logic [SEG_COUNT-1:0]        seg_any_s;
    logic [1:0]                  hi_idx_s;
    logic                        keep_zero_s;
    logic [KW-1:0]               fmt_keep_s;
    logic [SEG_COUNT-1:0][2:0]   fmt_user_s;
    logic [SEG_COUNT-1:0]        fmt_last_s;
    logic                        viol_s;
    logic [3:0][127:0]           seg_data_s;
    logic [3:0][15:0]            seg_keep_s;
    logic [3:0][2:0]             seg_user_s;
    logic [3:0]                  seg_last_s;
    logic [3:0]                  seg_valid_s;

    assign nonempty_s     = (count_r != 2'd0);
    // rdy_en_r holds tready low until the first edge after reset is released.
    assign axis_in_tready = rdy_en_r && (count_r < 2'd2) && !reset;
    assign push_s         = axis_in_tvalid && axis_in_tready;
    assign seg_tready_s   = {seg3_tready, seg2_tready, seg1_tready, seg0_tready};
    assign seg_rdy_all_s  = &seg_tready_s[SEG_COUNT-1:0];
    assign pop_s          = nonempty_s && seg_rdy_all_s;

    // Per-segment formatting of the incoming beat and violation detection.
    always_comb begin
        fmt_keep_s  = axis_in_tkeep;
        seg_any_s   = {SEG_COUNT{1'b0}};
        hi_idx_s    = 2'd0;
        fmt_user_s  = {(3*SEG_COUNT){1'b0}};
        fmt_last_s  = {SEG_COUNT{1'b0}};
        keep_zero_s = (axis_in_tkeep == {KW{1'b0}});
        for (int k = 0; k < SEG_COUNT; k++) begin
            seg_any_s[k] = |axis_in_tkeep[16*k +: 16];
            hi_idx_s     = seg_any_s[k] ? k[1:0] : hi_idx_s;
        end
        for (int k = 0; k < SEG_COUNT; k++) begin
            fmt_last_s[k] = axis_in_tlast && seg_any_s[k] && (hi_idx_s == k[1:0]);
            fmt_user_s[k] = {fmt_last_s[k] && axis_in_tuser, 1'b0, seg_any_s[k]};
        end
        fmt_user_s[0][1] = (state_r == IDLE);
        // An empty last beat still has to close the packet, so substitute one flagged byte.
        if (axis_in_tlast && keep_zero_s) begin
            fmt_keep_s[15:0] = 16'h0001;
            fmt_user_s[0][0] = 1'b1;
            fmt_user_s[0][2] = 1'b1;
            fmt_last_s[0]    = 1'b1;
        end else begin
            fmt_keep_s = axis_in_tkeep;
        end
        viol_s = (!axis_in_tlast && (axis_in_tkeep != {KW{1'b1}}))
               || ((state_r == IDLE) && (axis_in_tkeep[15:0] == 16'h0000))
               || (axis_in_tlast && keep_zero_s);
    end

    // Packet state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet state transitions, advanced only on accepted beats.
    always_comb begin
        state_nxt_s = state_r;
        if (push_s) begin
            case (state_r)
                IDLE:    state_nxt_s = axis_in_tlast ? IDLE : IN_PKT;
                IN_PKT:  state_nxt_s = axis_in_tlast ? IDLE : IN_PKT;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Two-entry FIFO of formatted beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                data_r[i] <= {DW{1'b0}};
                keep_r[i] <= {KW{1'b0}};
                user_r[i] <= {(3*SEG_COUNT){1'b0}};
                last_r[i] <= {SEG_COUNT{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
            rdy_en_r <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
            if (push_s) begin
                data_r[wr_ptr_r] <= axis_in_tdata;
                keep_r[wr_ptr_r] <= fmt_keep_s;
                user_r[wr_ptr_r] <= fmt_user_s;
                last_r[wr_ptr_r] <= fmt_last_s;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Packet and violation counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_r   <= 32'd0;
            viol_count_r  <= 16'd0;
            viol_sticky_r <= 1'b0;
        end else begin
            if (pop_s && (|last_r[rd_ptr_r])) begin
                pkt_count_r <= pkt_count_r + 32'd1;
            end
            if (push_s && viol_s) begin
                viol_sticky_r <= 1'b1;
                if (viol_count_r != 16'hFFFF) begin
                    viol_count_r <= viol_count_r + 16'd1;
                end
            end
        end
    end

    // FIFO head onto the segment outputs; inactive segments stay zero.
    always_comb begin
        seg_data_s  = {512{1'b0}};
        seg_keep_s  = {64{1'b0}};
        seg_user_s  = {12{1'b0}};
        seg_last_s  = 4'b0000;
        seg_valid_s = 4'b0000;
        for (int k = 0; k < SEG_COUNT; k++) begin
            if (nonempty_s) begin
                seg_data_s[k]  = data_r[rd_ptr_r][128*k +: 128];
                seg_keep_s[k]  = keep_r[rd_ptr_r][16*k +: 16];
                seg_user_s[k]  = user_r[rd_ptr_r][k];
                seg_last_s[k]  = last_r[rd_ptr_r][k];
                seg_valid_s[k] = 1'b1;
            end else begin
                seg_valid_s[k] = 1'b0;
            end
        end
    end

    assign seg0_tdata  = seg_data_s[0];
    assign seg0_tkeep  = seg_keep_s[0];
    assign seg0_tuser  = seg_user_s[0];
    assign seg0_tlast  = seg_last_s[0];
    assign seg0_tvalid = seg_valid_s[0];
    assign seg1_tdata  = seg_data_s[1];
    assign seg1_tkeep  = seg_keep_s[1];
    assign seg1_tuser  = seg_user_s[1];
    assign seg1_tlast  = seg_last_s[1];
    assign seg1_tvalid = seg_valid_s[1];
    assign seg2_tdata  = seg_data_s[2];
    assign seg2_tkeep  = seg_keep_s[2];
    assign seg2_tuser  = seg_user_s[2];
    assign seg2_tlast  = seg_last_s[2];
    assign seg2_tvalid = seg_valid_s[2];
    assign seg3_tdata  = seg_data_s[3];
    assign seg3_tkeep  = seg_keep_s[3];
    assign seg3_tuser  = seg_user_s[3];
    assign seg3_tlast  = seg_last_s[3];
    assign seg3_tvalid = seg_valid_s[3];

    assign pkt_count   = pkt_count_r;
    assign viol_count  = viol_count_r;
    assign viol_sticky = viol_sticky_r;

endmodule

// File: tb/tb_axis_to_dcmac.sv
// Scoreboard bench for axis_to_dcmac: expected segment beats are queued at acceptance
// and compared as the DUT presents them.
module tb_axis_to_dcmac;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] axis_in_tdata;
    logic [63:0]  axis_in_tkeep;
    logic         axis_in_tuser, axis_in_tlast, axis_in_tvalid, axis_in_tready;
    logic [127:0] seg0_tdata, seg1_tdata, seg2_tdata, seg3_tdata;
    logic [15:0]  seg0_tkeep, seg1_tkeep, seg2_tkeep, seg3_tkeep;
    logic [2:0]   seg0_tuser, seg1_tuser, seg2_tuser, seg3_tuser;
    logic         seg0_tlast, seg1_tlast, seg2_tlast, seg3_tlast;
    logic         seg0_tvalid, seg1_tvalid, seg2_tvalid, seg3_tvalid;
    logic         rdy;
    logic [31:0]  pkt_count;
    logic [15:0]  viol_count;
    logic         viol_sticky;

    int           checks = 0;
    int           errors = 0;
    int           accepted = 0;
    logic         in_pkt = 1'b0;
    int           exp_pkt = 0;
    int           exp_viol = 0;
    logic [591:0] exp_q[$];
    logic [591:0] held;
    logic         stalled = 1'b0;

    axis_to_dcmac #(.SEG_COUNT(4), .DW(512)) dut (
        .clk(clk), .reset(reset),
        .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep),
        .axis_in_tuser(axis_in_tuser), .axis_in_tlast(axis_in_tlast),
        .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
        .seg0_tdata(seg0_tdata), .seg0_tkeep(seg0_tkeep), .seg0_tuser(seg0_tuser),
        .seg0_tlast(seg0_tlast), .seg0_tvalid(seg0_tvalid), .seg0_tready(rdy),
        .seg1_tdata(seg1_tdata), .seg1_tkeep(seg1_tkeep), .seg1_tuser(seg1_tuser),
        .seg1_tlast(seg1_tlast), .seg1_tvalid(seg1_tvalid), .seg1_tready(rdy),
        .seg2_tdata(seg2_tdata), .seg2_tkeep(seg2_tkeep), .seg2_tuser(seg2_tuser),
        .seg2_tlast(seg2_tlast), .seg2_tvalid(seg2_tvalid), .seg2_tready(rdy),
        .seg3_tdata(seg3_tdata), .seg3_tkeep(seg3_tkeep), .seg3_tuser(seg3_tuser),
        .seg3_tlast(seg3_tlast), .seg3_tvalid(seg3_tvalid), .seg3_tready(rdy),
        .pkt_count(pkt_count), .viol_count(viol_count), .viol_sticky(viol_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [591:0] obs, input logic [591:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per segment k, bits [148k +: 148] = {tdata, tkeep, err, sop, ena, tlast}.
    function automatic logic [591:0] model(input logic [511:0] d, input logic [63:0] kp,
                                           input logic l, input logic u, input logic sop);
        logic [591:0] r;
        logic [15:0]  kk;
        logic         en, ls, er, sp;
        int           hi;
        r  = '0;
        hi = -1;
        for (int k = 0; k < 4; k++) if (kp[16*k +: 16] != 16'h0) hi = k;
        for (int k = 0; k < 4; k++) begin
            kk = kp[16*k +: 16];
            en = (kk != 16'h0);
            ls = l && (k == hi);
            er = ls && u;
            sp = (k == 0) && sop;
            if (l && (kp == 64'h0) && (k == 0)) begin
                kk = 16'h0001; en = 1'b1; ls = 1'b1; er = 1'b1;
            end
            r[148*k +: 148] = {d[128*k +: 128], kk, er, sp, en, ls};
        end
        return r;
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic send(input logic [511:0] d, input logic [63:0] kp, input logic l, input logic u);
        logic t, ok, v;
        ok = 1'b0;
        axis_in_tdata = d; axis_in_tkeep = kp; axis_in_tlast = l; axis_in_tuser = u;
        axis_in_tvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            t = axis_in_tready;
            @(posedge clk);
            if (t) begin
                ok = 1'b1;
                exp_q.push_back(model(d, kp, l, u, !in_pkt));
                v = (!l && kp != 64'hFFFF_FFFF_FFFF_FFFF) || (!in_pkt && kp[15:0] == 16'h0)
                    || (l && kp == 64'h0);
                if (v && exp_viol < 65535) exp_viol++;
                in_pkt = !l;
                accepted++;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", {591'd0, ok}, 592'd1);
        @(negedge clk);
        axis_in_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain", exp_q.size(), 592'd0);
        @(negedge clk);
    endtask

    // Output monitor: scoreboard pop on handshake, hold check while stalled.
    always @(negedge clk) begin
        logic [591:0] obs, e;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            check("tvalid_eq", {seg3_tvalid, seg2_tvalid, seg1_tvalid}, {3{seg0_tvalid}});
            obs = {seg3_tdata, seg3_tkeep, seg3_tuser, seg3_tlast,
                   seg2_tdata, seg2_tkeep, seg2_tuser, seg2_tlast,
                   seg1_tdata, seg1_tkeep, seg1_tuser, seg1_tlast,
                   seg0_tdata, seg0_tkeep, seg0_tuser, seg0_tlast};
            if (seg0_tvalid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", exp_q.size(), 592'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", obs, e);
                    if (e[0] | e[148] | e[296] | e[444]) exp_pkt++;
                end
                stalled = 1'b0;
            end else if (seg0_tvalid) begin
                if (stalled) check("stall_hold", obs, held);
                held    = obs;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        logic [511:0] d;
        int base;
        reset = 1'b1; rdy = 1'b1;
        axis_in_tvalid = 1'b0; axis_in_tdata = '0; axis_in_tkeep = '0;
        axis_in_tlast = 1'b0; axis_in_tuser = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", {seg3_tvalid, seg2_tvalid, seg1_tvalid, seg0_tvalid}, 592'd0);
        check("rst_tready", axis_in_tready, 592'd0);
        check("rst_pkt", pkt_count, 592'd0);
        check("rst_viol", {viol_sticky, viol_count}, 592'd0);
        check("rst_data", {seg0_tdata, seg0_tuser, seg3_tlast}, 592'd0);
        #2 reset = 1'b0;
        @(negedge clk);
        check("tready_after_rst", axis_in_tready, 592'd1);

        // single 64-byte packet
        send(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        drain();
        check("pkt_single", pkt_count, 592'd1);

        // 65-byte packet
        send(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(rand_data(), 64'h1, 1'b1, 1'b0);
        drain();
        check("pkt_65", pkt_count, 592'd2);

        // backpressure with 4 beats offered
        rdy  = 1'b0;
        base = accepted;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, (i == 3), 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_tready", axis_in_tready, 592'd0);
                check("bp_accepted", accepted - base, 592'd2);
                rdy = 1'b1;
            end
        join
        drain();
        check("pkt_bp", pkt_count, 592'd3);

        // error packet ending in seg1
        send(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(rand_data(), 64'hFFFF_FFFF, 1'b1, 1'b1);
        drain();
        check("pkt_err", pkt_count, 592'd4);
        check("no_viol_yet", {viol_sticky, viol_count}, 592'd0);

        // empty last beat violation, then saturation
        d = rand_data();
        send(d, 64'h0, 1'b1, 1'b0);
        check("viol_one", viol_count, 592'd1);
        check("viol_sticky", viol_sticky, 592'd1);
        for (int i = 0; i < 69999; i++) send(d, 64'h0, 1'b1, 1'b0);
        drain();
        check("viol_sat", viol_count, 592'd65535);
        check("viol_model", viol_count, exp_viol);
        check("pkt_many", pkt_count, exp_pkt);

        // reset in the middle of a packet
        rdy = 1'b0;
        send(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", seg0_tvalid, 592'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tvalid", {seg3_tvalid, seg2_tvalid, seg1_tvalid, seg0_tvalid}, 592'd0);
        check("mid_rst_tready", axis_in_tready, 592'd0);
        exp_q.delete(); in_pkt = 1'b0; exp_pkt = 0; exp_viol = 0;
        @(negedge clk);
        #2 reset = 1'b0; rdy = 1'b1;
        @(negedge clk);
        check("post_rst_pkt", pkt_count, 592'd0);
        check("post_rst_viol", {viol_sticky, viol_count}, 592'd0);
        send(rand_data(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        send(rand_data(), 64'hFF, 1'b1, 1'b0);
        drain();
        check("pkt_after_rst", pkt_count, 592'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_to_dcmac.md
Name: axis_to_dcmac

Overview:
- Converts an ordinary AXI stream into the segmented TX streams consumed by the DCMAC transmit port, one 128-bit segment per stream.
- Sits between the user packet source and DCMAC TX; mirror of the RX-side segmented-to-AXIS conversion.
- Buffers two input beats and generates per-segment ena/sop/err/tlast from tkeep, tlast and tuser.
- Counts packets sent and protocol violations.

Parameters:
SEG_COUNT, 4, number of active 128-bit segments (2 or 4)
DW, 128*SEG_COUNT, input data width in bits; must equal 128*SEG_COUNT

Ports:
clk  input  1  clock for all logic
reset  input  1  asynchronous, active-high reset
axis_in_tdata  input  DW  input beat data, byte 0 in bits [7:0]
axis_in_tkeep  input  DW/8  input byte enables
axis_in_tuser  input  1  packet error, sampled on tlast beat only
axis_in_tlast  input  1  last beat of packet
axis_in_tvalid  input  1  input valid
axis_in_tready  output  1  input ready
segN_tdata  output  128  segment N data, N=0..3
segN_tkeep  output  16  segment N byte enables
segN_tuser  output  3  segment N {err, sop, ena}
segN_tlast  output  1  segment N end of packet
segN_tvalid  output  1  segment N valid
segN_tready  input  1  segment N ready
pkt_count  output  32  packets emitted, wraps
viol_count  output  16  protocol violations, saturating
viol_sticky  output  1  set on first violation, cleared only by reset

Behaviour:
- Reset (async, active-high): FIFO empty, state IDLE, counters 0, viol_sticky 0, axis_in_tready 0, all segN_tvalid 0, all other outputs 0. Outputs leave reset on the first clk edge after reset falls.
- Segment mapping: segment k takes tdata[128k+127:128k] and tkeep[16k+15:16k].
- When SEG_COUNT=2, seg2/seg3 outputs are held 0 and their tready inputs are ignored.
- Input side: a 2-entry FIFO of formatted beats.
  - axis_in_tready = (count<2) and not reset.
  - Push when tvalid and tready. Push and pop in the same cycle leave count unchanged.
  - Latency: an accepted beat appears on the segment outputs on the next cycle when the FIFO was empty.
- Output side: all active segN_tvalid equal (FIFO nonempty). Pop occurs when the AND of all active segN_tready is 1 and the FIFO is nonempty. Outputs stay stable while stalled.
- Formatting is done at push time.
  - ena_k = OR of segment k tkeep. On a tlast beat, segments above the highest enabled segment have ena 0.
  - sop: set on seg0 only, on the first beat of a packet (state IDLE).
  - tlast: set on the highest enabled segment of a tlast beat; all other tlast bits 0.
  - err: set equal to axis_in_tuser on the tlast segment only.
- State machine, advanced on push only:
  - IDLE -> IN_PKT on a non-tlast beat.
  - IDLE stays IDLE on a tlast beat (single-beat packet).
  - IN_PKT -> IDLE on a tlast beat.
- Violations: each increments viol_count (saturates at 65535) and sets viol_sticky. Multiple violations in one beat count once.
  - (a) Non-tlast beat whose tkeep is not all ones: forwarded as formatted.
  - (b) IDLE beat with seg0 tkeep = 0: forwarded with sop still on seg0.
  - (c) tlast beat with tkeep all zero: emitted with seg0 ena=1, tlast=1, tkeep=16'h0001, err=1; other segments ena=0.
- pkt_count increments on the pop of a beat containing a tlast segment; wraps at 2^32.
- Reset mid-packet: FIFO contents discarded, no tlast emitted, next accepted beat is treated as SOP.

Test Plan:
- Single 64-byte packet: 1 beat, tkeep all ones, tlast=1 -> one output cycle; seg0..3 ena=1; seg0 sop=1; seg3 tlast=1; err=0; pkt_count=1.
- 65-byte packet: beat0 full, beat1 tkeep=64'h1 with tlast -> cycle 1: all ena, sop seg0. Cycle 2: seg0 ena=1, tlast=1, tkeep=16'h0001; seg1..3 ena=0; sop=0 everywhere.
- Backpressure: seg tready low for 5 cycles while 4 beats are offered -> 2 accepted, then axis_in_tready=0. After release, beats emerge in order with no loss or duplication; each beat held stable while stalled.
- Error packet: 2-beat packet with tuser=1 on a last beat with tkeep=64'hFFFF_FFFF -> seg1 tlast=1, seg1 err=1; seg2/3 ena=0.
- Violation: tlast beat with tkeep=0 -> substituted seg0 ena=1, tkeep=16'h0001, err=1; viol_count=1; viol_sticky=1. 70000 such beats -> viol_count=65535.
- Reset mid-packet: assert reset after beat0 of a 3-beat packet -> all tvalid drop immediately. After reset, a new packet's first segment carries sop=1; pkt_count=0 before it completes.
